// File: rtl/mmio_store_monitor.sv
// Passive snoop of core MMIO stores into a small event FIFO.
// Tracks run/halt/done and counts captured and dropped stores.
module mmio_store_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] HALT_ADDR = 32'h00000FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_out,
    input  logic [3:0]  byte_enable,
    input  logic        we,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [31:0] ev_addr,
    output logic [31:0] ev_data,
    output logic [3:0]  ev_be,
    output logic [31:0] store_count,
    output logic [15:0] drop_count,
    output logic        halted,
    output logic        done
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 68;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;

    logic empty;
    logic full;
    logic capture;
    logic pop;
    logic push;
    logic drop;

    // Extra pointer MSB separates full from empty when indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign capture = we && address[11] && (state != DONE);
    assign pop     = ev_valid && ev_ready;
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign ev_valid = !empty;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign ev_addr  = head[67:36];
    assign ev_data  = head[35:4];
    assign ev_be    = head[3:0];

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr[AW-1:0]] <= {address, data_out, byte_enable};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            store_count <= '0;
            drop_count  <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + PTR_ONE;
                store_count <= store_count + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            halted <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (address == HALT_ADDR) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (empty && !push) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_store_monitor.sv
// Directed vector bench for mmio_store_monitor.
// Table vectors plus overflow and reset-mid-run sequences.
module tb_mmio_store_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data_out;
    logic [3:0]  byte_enable;
    logic        we;
    logic        ev_valid;
    logic        ev_ready;
    logic [31:0] ev_addr;
    logic [31:0] ev_data;
    logic [3:0]  ev_be;
    logic [31:0] store_count;
    logic [15:0] drop_count;
    logic        halted;
    logic        done;

    int tests = 0;
    int fails = 0;

    mmio_store_monitor #(.DEPTH(8), .HALT_ADDR(32'h00000FFC)) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .data_out(data_out),
        .byte_enable(byte_enable),
        .we(we),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_addr(ev_addr),
        .ev_data(ev_data),
        .ev_be(ev_be),
        .store_count(store_count),
        .drop_count(drop_count),
        .halted(halted),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic        rdy;
        logic        xv;
        logic        xe;
        logic [31:0] xa;
        logic [31:0] xd;
        logic [3:0]  xb;
        logic [31:0] xs;
        logic [15:0] xdc;
        logic        xh;
        logic        xdn;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(
        input logic rst, input logic w,
        input logic [31:0] a, input logic [31:0] d,
        input logic [3:0] b, input logic rdy,
        input logic xv, input logic xe,
        input logic [31:0] xa, input logic [31:0] xd,
        input logic [3:0] xb, input logic [31:0] xs,
        input logic [15:0] xdc, input logic xh,
        input logic xdn);
        vec_t v;
        v.rst = rst; v.w = w; v.a = a; v.d = d;
        v.b = b; v.rdy = rdy; v.xv = xv; v.xe = xe;
        v.xa = xa; v.xd = xd; v.xb = xb; v.xs = xs;
        v.xdc = xdc; v.xh = xh; v.xdn = xdn;
        return v;
    endfunction

    task automatic step(
        input logic r, input logic w,
        input logic [31:0] a, input logic [31:0] d,
        input logic [3:0] b, input logic rdy);
        reset = r; we = w; address = a;
        data_out = d; byte_enable = b; ev_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check(
        input string nm, input logic xv, input logic xe,
        input logic [31:0] xa, input logic [31:0] xd,
        input logic [3:0] xb, input logic [31:0] xs,
        input logic [15:0] xdc, input logic xh,
        input logic xdn);
        logic ok;
        ok = (ev_valid === xv) && (store_count === xs) &&
             (drop_count === xdc) && (halted === xh) &&
             (done === xdn);
        if (xe) begin
            ok = ok && (ev_addr === xa) && (ev_data === xd) &&
                 (ev_be === xb);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got v=%b a=%h d=%h be=%h sc=%0d dc=%0d h=%b dn=%b; want v=%b a=%h d=%h be=%h sc=%0d dc=%0d h=%b dn=%b",
                     nm, ev_valid, ev_addr, ev_data, ev_be,
                     store_count, drop_count, halted, done,
                     xv, xa, xd, xb, xs, xdc, xh, xdn);
        end
    endtask

    initial begin
        // reset, filtering, single store, hold, pop
        tbl[0]  = mk(1,0,0,0,0,0,        0,0,0,0,0,0,0,0,0);
        tbl[1]  = mk(0,1,32'h100,1,4'hF,0, 0,0,0,0,0,0,0,0,0);
        tbl[2]  = mk(0,1,32'h7FC,2,4'hF,0, 0,0,0,0,0,0,0,0,0);
        tbl[3]  = mk(0,0,32'h900,3,4'hF,0, 0,0,0,0,0,0,0,0,0);
        tbl[4]  = mk(0,1,32'h800,32'hDEADBEEF,4'hF,0,
                     1,1,32'h800,32'hDEADBEEF,4'hF,1,0,0,0);
        tbl[5]  = mk(0,0,0,0,0,0,
                     1,1,32'h800,32'hDEADBEEF,4'hF,1,0,0,0);
        tbl[6]  = mk(0,0,0,0,0,1,        0,0,0,0,0,1,0,0,0);
        // halt with drain
        tbl[7]  = mk(1,0,0,0,0,0,        0,0,0,0,0,0,0,0,0);
        tbl[8]  = mk(0,1,32'h800,32'h11,4'h3,0,
                     1,1,32'h800,32'h11,4'h3,1,0,0,0);
        tbl[9]  = mk(0,1,32'h804,32'h22,4'hC,0,
                     1,1,32'h800,32'h11,4'h3,2,0,0,0);
        tbl[10] = mk(0,1,32'hFFC,32'h1,4'hF,0,
                     1,1,32'h800,32'h11,4'h3,3,0,1,0);
        tbl[11] = mk(0,1,32'h808,32'h33,4'h1,0,
                     1,1,32'h800,32'h11,4'h3,4,0,1,0);
        tbl[12] = mk(0,0,0,0,0,1,
                     1,1,32'h804,32'h22,4'hC,4,0,1,0);
        tbl[13] = mk(0,0,0,0,0,1,
                     1,1,32'hFFC,32'h1,4'hF,4,0,1,0);
        tbl[14] = mk(0,0,0,0,0,1,
                     1,1,32'h808,32'h33,4'h1,4,0,1,0);
        tbl[15] = mk(0,0,0,0,0,1,        0,0,0,0,0,4,0,1,0);
        tbl[16] = mk(0,0,0,0,0,1,        0,0,0,0,0,4,0,1,1);
        tbl[17] = mk(0,1,32'h900,5,4'hF,1, 0,0,0,0,0,4,0,1,1);
        tbl[18] = mk(0,1,32'hFFC,6,4'hF,1, 0,0,0,0,0,4,0,1,1);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].w, tbl[i].a, tbl[i].d,
                 tbl[i].b, tbl[i].rdy);
            check($sformatf("vec%0d", i), tbl[i].xv, tbl[i].xe,
                  tbl[i].xa, tbl[i].xd, tbl[i].xb, tbl[i].xs,
                  tbl[i].xdc, tbl[i].xh, tbl[i].xdn);
        end

        // overflow: 10 stores into 8 entries
        step(1, 0, 0, 0, 0, 0);
        check("ovf_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h800 + 32'(4 * i), 32'h100 + 32'(i),
                 4'hF, 0);
            check($sformatf("ovf_push%0d", i), 1, 1, 32'h800,
                  32'h100, 4'hF, (i < 8) ? 32'(i + 1) : 32'd8,
                  (i < 8) ? 16'd0 : 16'(i - 7), 0, 0);
        end

        // full: pop 0x800 and push 0x840 together
        step(0, 1, 32'h840, 32'hAA, 4'hF, 1);
        check("full_pushpop", 1, 1, 32'h804, 32'h101, 4'hF,
              9, 2, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (i < 7) begin
                check($sformatf("drain%0d", i), 1, 1,
                      32'h804 + 32'(4 * i), 32'h101 + 32'(i),
                      4'hF, 9, 2, 0, 0);
            end else begin
                check("drain_last", 1, 1, 32'h840, 32'hAA,
                      4'hF, 9, 2, 0, 0);
            end
        end
        step(0, 0, 0, 0, 0, 1);
        check("drain_empty", 0, 0, 0, 0, 0, 9, 2, 0, 0);

        // five queued, halt by a read of HALT_ADDR, then reset
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'h800 + 32'(4 * i), 32'h200 + 32'(i),
                 4'h5, 0);
        end
        check("mid_queued", 1, 1, 32'h800, 32'h200, 4'h5,
              14, 2, 0, 0);
        step(0, 0, 32'hFFC, 0, 0, 0);
        check("mid_halt", 1, 1, 32'h800, 32'h200, 4'h5,
              14, 2, 1, 0);
        step(1, 1, 32'h820, 32'h300, 4'hF, 1);
        check("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_store_monitor.md
MMIO_STORE_MONITOR -- requirements
Module: mmio_store_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter HALT_ADDR, default 32'h00000FFC: address that stops the run.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port address, input, 32 bits: core bus address (snooped).
REQ-006 SHALL have port data_out, input, 32 bits: core store data (snooped).
REQ-007 SHALL have port byte_enable, input, 4 bits: core byte lanes (snooped).
REQ-008 SHALL have port we, input, 1 bit: core write strobe (snooped).
REQ-009 SHALL have port ev_valid, output, 1 bit: FIFO head entry available.
REQ-010 SHALL have port ev_ready, input, 1 bit: consumer accepts the head entry.
REQ-011 SHALL have port ev_addr, output, 32 bits: address of the head entry.
REQ-012 SHALL have port ev_data, output, 32 bits: data of the head entry.
REQ-013 SHALL have port ev_be, output, 4 bits: byte_enable of the head entry.
REQ-014 SHALL have port store_count, output, 32 bits: number of captured MMIO stores.
REQ-015 SHALL have port drop_count, output, 16 bits: number of stores lost to overflow.
REQ-016 SHALL have port halted, output, 1 bit: the halt address has been seen.
REQ-017 SHALL have port done, output, 1 bit: halted and FIFO fully drained.

Function
REQ-018 SHALL be a passive snoop that never drives the core bus.
REQ-019 SHALL define a capture cycle as we==1 AND address[11]==1 AND FSM state != DONE.
REQ-020 SHALL push {address, data_out, byte_enable} on a capture cycle when not full. The entry SHALL be visible on ev_* no earlier than the next cycle; there is no combinational fall-through.
REQ-021 SHALL pop the head entry on any cycle where ev_valid and ev_ready are both 1.
REQ-022 SHALL hold ev_addr, ev_data and ev_be stable while ev_valid==1 and ev_ready==0.
REQ-023 SHALL drive ev_valid = (occupancy != 0), from registered state only.
REQ-024 SHALL accept the push when a push and a pop occur on the same cycle with the FIFO full; occupancy is unchanged.
REQ-025 SHALL, on a push and a pop in the same cycle with the FIFO empty, pop nothing and push the entry.
REQ-026 SHALL, on a capture cycle with the FIFO full and no pop, drop the entry and increment drop_count. drop_count SHALL saturate at 16'hFFFF.
REQ-027 SHALL increment store_count on every accepted push, wrapping modulo 2^32.
REQ-028 SHALL use read and write pointers of log2(DEPTH)+1 bits that wrap naturally; full and empty are decoded from the MSB and the index bits.
REQ-029 SHALL implement a three-state FSM with states RUN, HALT and DONE; the reset state is RUN.
REQ-030 SHALL move from RUN to HALT on any cycle with address==HALT_ADDR, regardless of we.
REQ-031 SHALL move from HALT to DONE on the first cycle with occupancy==0 and no push.
REQ-032 SHALL keep DONE sticky until reset.
REQ-033 SHALL still capture, in the RUN->HALT cycle, a store to HALT_ADDR that meets the capture rule (0xFFC has bit 11 set).
REQ-034 SHALL continue capturing stores while in HALT.
REQ-035 SHALL drive halted = (state != RUN) and done = (state == DONE), both registered.

Reset
REQ-036 SHALL, on reset==1 at a rising edge, clear both pointers, store_count, drop_count and FIFO occupancy, and set state to RUN.
REQ-037 SHALL, after reset, present ev_valid=0, halted=0, done=0, store_count=0 and drop_count=0.
REQ-038 SHALL discard any in-flight push or pop when reset is asserted mid-operation; reset has priority over all other events.
REQ-039 SHALL leave FIFO data storage unreset; ev_addr, ev_data and ev_be are don't-care while ev_valid==0.

Verification
REQ-040 SHALL verify a single store: we=1, address=0x800, data_out=0xDEADBEEF, byte_enable=4'hF, ev_ready=0 -> next cycle ev_valid=1, ev_addr=0x800, ev_data=0xDEADBEEF, ev_be=4'hF, store_count=1.
REQ-041 SHALL verify filtering: stores to 0x100 and 0x7FC, plus a read (we=0) at 0x900 -> ev_valid stays 0 and store_count=0.
REQ-042 SHALL verify overflow: 10 consecutive stores to 0x800..0x824 with ev_ready=0 and DEPTH=8 -> 8 entries held, drop_count=2, store_count=8; draining returns 0x800..0x81C in order.
REQ-043 SHALL verify full with simultaneous pop and push: FIFO full, ev_ready=1 and a store to 0x840 in the same cycle -> occupancy stays 8 and the last entry popped out is 0x840.
REQ-044 SHALL verify halt with drain: 2 entries queued, then a store to 0xFFC with data 0x1 -> halted=1 next cycle and 3 entries queued; with ev_ready=1, done=1 on the cycle after the FIFO empties, and later stores are ignored.
REQ-045 SHALL verify reset mid-operation: 5 entries queued in HALT, then reset pulsed for 1 cycle -> ev_valid=0, halted=0, done=0, and both counters 0.
